// File: rtl/bus_deser.sv
// bus_deser: collects a qualified serial bit stream into WIDTH-bit words with
// start-of-frame realignment and a valid/ready output handshake.
module bus_deser #(
  parameter int WIDTH     = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             in,
  input  logic             in_vld,
  input  logic             in_sof,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             sof_err
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] sh_q, sh_d, mask;
  logic [WIDTH-1:0] out_q, out_d, word;
  logic             out_vld_q, out_vld_d, sof_err_q, sof_err_d;
  logic             acc, realign;
  // Stall only when a word is held and the next one would complete.
  assign in_rdy  = !(out_vld_q && cnt_q == LAST);
  assign out     = out_q;
  assign out_vld = out_vld_q;
  assign sof_err = sof_err_q;
  always_comb begin
    acc       = in_vld && in_rdy;
    realign   = acc && in_sof && cnt_q != '0;
    mask      = (WIDTH-1)'(1) << cnt_q;
    word      = {in, sh_q};
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    out_d     = out_q;
    out_vld_d = out_vld_q && !out_rdy;
    sof_err_d = realign;
    if (realign) begin
      sh_d  = (WIDTH-1)'(in);
      cnt_d = CW'(1);
    end else if (acc && cnt_q == LAST) begin
      out_d     = MSB_FIRST ? {<<{word}} : word;
      out_vld_d = 1'b1;
      cnt_d     = '0;
    end else if (acc) begin
      sh_d  = (sh_q & ~mask) | (mask & {(WIDTH-1){in}});
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q     <= '0;
      sh_q      <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      sof_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      sof_err_q <= sof_err_d;
    end
  end
endmodule

// File: tb/tb_bus_deser.sv
// tb_bus_deser: three bus_deser configurations share one stimulus stream and are
// checked every cycle against a bit-list model, plus directed literal checks.
module tb_bus_deser;
  logic clk = 1'b0, rstb = 1'b0, din = 1'b0, vld = 1'b0, sof = 1'b0, ordy = 1'b0;
  logic r0, r1, r2, v0, v1, v2, e0, e1, e2;
  logic [1:0] o0, o1;
  logic [3:0] o2;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  bus_deser #(.WIDTH(2), .MSB_FIRST(1'b0)) d0 (.clk(clk), .rstb(rstb), .in(din), .in_vld(vld),
    .in_sof(sof), .in_rdy(r0), .out(o0), .out_vld(v0), .out_rdy(ordy), .sof_err(e0));
  bus_deser #(.WIDTH(2), .MSB_FIRST(1'b1)) d1 (.clk(clk), .rstb(rstb), .in(din), .in_vld(vld),
    .in_sof(sof), .in_rdy(r1), .out(o1), .out_vld(v1), .out_rdy(ordy), .sof_err(e1));
  bus_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) d2 (.clk(clk), .rstb(rstb), .in(din), .in_vld(vld),
    .in_sof(sof), .in_rdy(r2), .out(o2), .out_vld(v2), .out_rdy(ordy), .sof_err(e2));

  // Model: per instance, the list of bits collected so far (position = arrival order).
  int          mw[3]    = '{2, 2, 4};
  bit          mm[3]    = '{1'b0, 1'b1, 1'b0};
  int          mn[3]    = '{0, 0, 0};
  logic [63:0] mbits[3] = '{64'd0, 64'd0, 64'd0};
  logic [63:0] mout[3]  = '{64'd0, 64'd0, 64'd0};
  bit          mov[3]   = '{1'b0, 1'b0, 1'b0};
  bit          mse[3]   = '{1'b0, 1'b0, 1'b0};

  function automatic bit mrdy(int k);
    return !(mov[k] && mn[k] == mw[k] - 1);
  endfunction

  task automatic mstep(int k);
    bit clr, done;
    logic [63:0] w;
    clr    = mov[k] && ordy;
    done   = 1'b0;
    mse[k] = 1'b0;
    if (vld && mrdy(k)) begin
      if (sof && mn[k] != 0) begin
        mbits[k] = 64'(din);
        mn[k]    = 1;
        mse[k]   = 1'b1;
      end else begin
        mbits[k] = (mbits[k] & ~(64'd1 << mn[k])) | (64'(din) << mn[k]);
        mn[k]++;
        if (mn[k] == mw[k]) begin
          w = 64'd0;
          for (int i = 0; i < mw[k]; i++)
            if (((mbits[k] >> i) & 64'd1) != 64'd0) w |= 64'd1 << (mm[k] ? mw[k] - 1 - i : i);
          mout[k] = w;
          mn[k]   = 0;
          done    = 1'b1;
        end
      end
    end
    mov[k] = (mov[k] && !clr) || done;
  endtask

  always @(posedge clk or negedge rstb) begin
    for (int k = 0; k < 3; k++) begin
      if (!rstb) begin
        mn[k] = 0; mbits[k] = 64'd0; mout[k] = 64'd0; mov[k] = 1'b0; mse[k] = 1'b0;
      end else mstep(k);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("d0_out", 64'(o0), mout[0]);  chk("d0_vld", 64'(v0), 64'(mov[0]));
    chk("d0_rdy", 64'(r0), 64'(mrdy(0))); chk("d0_err", 64'(e0), 64'(mse[0]));
    chk("d1_out", 64'(o1), mout[1]);  chk("d1_vld", 64'(v1), 64'(mov[1]));
    chk("d1_rdy", 64'(r1), 64'(mrdy(1))); chk("d1_err", 64'(e1), 64'(mse[1]));
    chk("d2_out", 64'(o2), mout[2]);  chk("d2_vld", 64'(v2), 64'(mov[2]));
    chk("d2_rdy", 64'(r2), 64'(mrdy(2))); chk("d2_err", 64'(e2), 64'(mse[2]));
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic b, input logic s);
    din = b; sof = s; vld = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  int sb[8] = '{1, 1, 0, 1, 0, 0, 1, 0};
  logic [1:0] sexp[4] = '{2'b11, 2'b10, 2'b00, 2'b01};
  logic [1:0] got[$];
  logic [3:0] got4[$];
  int drops, errs;

  initial begin
    for (int i = 0; i < 4; i++) begin
      din = 1'($urandom); vld = 1'($urandom); sof = 1'($urandom); ordy = 1'($urandom);
      tick();
      chk("rst_out", 64'(o0), 64'd0); chk("rst_vld", 64'(v0), 64'd0);
      chk("rst_rdy", 64'(r0), 64'd1); chk("rst_err", 64'(e0), 64'd0);
    end
    vld = 1'b0; sof = 1'b0; ordy = 1'b1; rstb = 1'b1;
    tick();
    send(1'b1, 1'b1); send(1'b0, 1'b0); vld = 1'b0;
    chk("basic_lsb_out", 64'(o0), 64'd1); chk("basic_msb_out", 64'(o1), 64'd2);
    chk("basic_vld", 64'(v0), 64'd1);
    chk("model_lsb", mout[0], 64'd1); chk("model_msb", mout[1], 64'd2);
    tick();
    chk("basic_vld_drop", 64'(v0), 64'd0);
    drops = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'(sb[i]), 1'(i == 0));
      if (!r0) drops++;
      if (v0) got.push_back(o0);
    end
    vld = 1'b0;
    tick();
    if (v0) got.push_back(o0);
    chk("stream_count", 64'(got.size()), 64'd4);
    chk("stream_rdy_drops", 64'(drops), 64'd0);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("stream_word", 64'(got[i]), 64'(sexp[i]));
    ordy = 1'b0;
    send(1'b1, 1'b0); send(1'b1, 1'b0);
    chk("bp_word", 64'(o0), 64'd3); chk("bp_vld", 64'(v0), 64'd1);
    send(1'b1, 1'b0); vld = 1'b0;
    chk("bp_rdy_low", 64'(r0), 64'd0); chk("bp_out_hold", 64'(o0), 64'd3);
    tick();
    chk("bp_rdy_still_low", 64'(r0), 64'd0); chk("bp_vld_hold", 64'(v0), 64'd1);
    ordy = 1'b1;
    tick();
    chk("bp_rdy_rise", 64'(r0), 64'd1); chk("bp_vld_clear", 64'(v0), 64'd0);
    ordy = 1'b0;
    send(1'b0, 1'b0); vld = 1'b0;
    chk("bp_next_word", 64'(o0), 64'd1); chk("bp_next_vld", 64'(v0), 64'd1);
    ordy = 1'b1;
    tick();
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    tick();
    errs = 0;
    send(1'b1, 1'b0); if (e2) errs++; if (v2) got4.push_back(o2);
    send(1'b0, 1'b0); if (e2) errs++; if (v2) got4.push_back(o2);
    send(1'b1, 1'b1); if (e2) errs++; if (v2) got4.push_back(o2);
    send(1'b1, 1'b0); if (e2) errs++; if (v2) got4.push_back(o2);
    send(1'b0, 1'b0); if (e2) errs++; if (v2) got4.push_back(o2);
    send(1'b0, 1'b0); if (e2) errs++; if (v2) got4.push_back(o2);
    vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (e2) errs++;
      if (v2) got4.push_back(o2);
    end
    chk("realign_errs", 64'(errs), 64'd1);
    chk("realign_count", 64'(got4.size()), 64'd1);
    if (got4.size() > 0) chk("realign_word", 64'(got4[0]), 64'd3);
    send(1'b1, 1'b0); vld = 1'b0;
    rstb = 1'b0;
    tick();
    chk("midrst_cleared", 64'(v0), 64'd0);
    rstb = 1'b1;
    tick();
    send(1'b0, 1'b0); send(1'b1, 1'b0); vld = 1'b0;
    chk("midrst_word", 64'(o0), 64'd2); chk("midrst_vld", 64'(v0), 64'd1);
    chk("model_midrst", mout[0], 64'd2);
    tick();
    for (int i = 0; i < 4000; i++) begin
      rstb = 1'($urandom_range(0, 199) != 0);
      vld  = 1'($urandom_range(0, 3) != 0);
      din  = 1'($urandom);
      sof  = 1'($urandom_range(0, 9) == 0);
      ordy = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    rstb = 1'b1; vld = 1'b0; sof = 1'b0;
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_deser.md
# bus_deser

Serial-to-parallel deserializer: the receive-side counterpart of the bus-to-single-line drive path in the test netlists. It collects a qualified 1-bit stream on `in` into a WIDTH-bit word and presents it on `out[WIDTH-1:0]` through a valid/ready output handshake. An optional start-of-frame marker realigns word boundaries. It sits between a serial link front-end and parallel bus consumers in the generated test designs.

## Interface
- `WIDTH`, 2: word width in bits; legal range 2..64.
- `MSB_FIRST`, 0: 0 places the first received bit in `out[0]`; 1 places it in `out[WIDTH-1]`.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rstb`  input  1  asynchronous, active-low reset.
- `in`  input  1  serial data bit.
- `in_vld`  input  1  `in` and `in_sof` are valid this cycle.
- `in_sof`  input  1  this bit is bit 0 of a new word.
- `in_rdy`  output  1  the block can accept a bit this cycle.
- `out`  output  WIDTH  assembled word.
- `out_vld`  output  1  `out` holds an unconsumed word.
- `out_rdy`  input  1  the consumer accepts `out` this cycle.
- `sof_err`  output  1  one-cycle pulse: a partial word was discarded by `in_sof`.

## Operation
- Accept event: `in_vld && in_rdy` at a rising edge. Outside accept events, `in` and `in_sof` are ignored.
- State:
  - bit counter `cnt`, $clog2(WIDTH) bits, range 0..WIDTH-1;
  - shift register `sh`, WIDTH-1 bits;
  - output register `out` with flag `out_vld`.
- `in_rdy = !(out_vld && cnt == WIDTH-1)`. It is decoded from registers only, so there is no combinational path from `out_rdy` or `in_vld`.
- Accept with `cnt < WIDTH-1` and no sof realignment:
  - the bit is stored at word position `cnt` (bit-reversed if MSB_FIRST);
  - `cnt` increments.
- Accept with `cnt == WIDTH-1` (only possible while `!out_vld`):
  - `out` loads the complete word: stored bits plus the current bit;
  - `out_vld` is set to 1 and `cnt` returns to 0.
- Accept with `in_sof == 1`:
  - `cnt != 0`: stored bits are discarded, `sof_err` pulses for 1 cycle, the current bit becomes bit 0, and `cnt` becomes 1.
  - `cnt == 0`: normal accept, no error.
  - Exception: with `cnt == WIDTH-1` and `in_sof == 1`, the word does not complete. The partial word is discarded, `sof_err` pulses, and `cnt` becomes 1.
- Output handshake: `out_vld && out_rdy` at an edge clears `out_vld`. `out` keeps its value; it is don't-care to the consumer once `out_vld` is 0.
- `out` and `out_vld` never change while `out_vld && !out_rdy`.
- Simultaneous events:
  - An output handshake and an accept of a non-final bit in the same cycle are both honored.
  - A final-bit load and an output handshake cannot coincide, because `in_rdy` is 0 in that case.
- Reset (asserted at any time, including mid-word or mid-stall):
  - `cnt` = 0, `sh` = 0, `out` = 0, `out_vld` = 0, `sof_err` = 0, so `in_rdy` = 1;
  - any partial or held word is lost.

## Timing
- Latency: when the last bit of a word is accepted at edge N, `out_vld` is 1 from just after edge N.
- Throughput: one bit per cycle sustained, provided the consumer takes each word within WIDTH-1 cycles of `out_vld` rising.
- Stall: if the consumer holds `out_rdy` low, `in_rdy` drops once the next word has WIDTH-1 bits stored. It rises in the cycle after `out_vld && out_rdy`.
- `sof_err` is asserted in the cycle after the offending accept edge, for exactly 1 cycle.
- Release of `rstb` is synchronous to `clk` externally; the first accept is possible at the first edge after deassertion.

## Test plan
All scenarios use WIDTH=2, MSB_FIRST=0 unless stated.

- Reset: hold `rstb` low, toggle inputs -> `out`=0, `out_vld`=0, `in_rdy`=1, `sof_err`=0 throughout.
- Basic: bits 1 then 0 with `in_sof` on the first and `out_rdy`=1 -> `out`=2'b01 with `out_vld` high for 1 cycle after the second edge. Repeat with MSB_FIRST=1 -> 2'b10.
- Streaming: 8 continuous bits 1,1,0,1,0,0,1,0 with `out_rdy`=1 -> words 2'b11, 2'b10, 2'b00, 2'b01; `in_rdy` never drops.
- Backpressure: `out_rdy`=0 after word 2'b11, then send bit 1 -> `in_rdy` drops with `cnt`=1 and `out` stable at 2'b11. Raise `out_rdy` for 1 cycle -> `in_rdy` rises next cycle, and the next bit 0 completes 2'b01.
- Realign (WIDTH=4): send 1,0, then `in_sof` with bits 1,1,0,0 -> `sof_err` pulses once and the only word is 4'b0011.
- Mid-word reset: assert `rstb` low after 1 bit, release, send 0,1 -> `out`=2'b10 with no stale data.
